// File: rtl/ct_mul_seq25.sv
`default_nettype none
// ============================================================================
// Module      : ct_mul_seq25
// Description : Sequential shift-and-add multiplier, 25x25 unsigned -> 50-bit
//               product. One adder, one 51-bit accumulator/shift register,
//               start/done handshake driven by a small FSM.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_mul_seq25 #(
   parameter int WIDTH = 25,
   parameter int STW   = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [WIDTH-1:0]   inA,
   input  logic [WIDTH-1:0]   inB,
   output logic [2*WIDTH-1:0] out_product,
   output logic               donee,
   output logic               busy,
   output logic [STW-1:0]     state
);

   localparam int            CW     = $clog2(WIDTH);
   localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

   typedef enum logic [STW-1:0] {
      S_IDLE  = 3'd0,
      S_CHECK = 3'd1,
      S_ADD   = 3'd2,
      S_SHIFT = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    a_q, a_d;     // latched multiplicand
   logic [2*WIDTH:0]    p_q, p_d;     // {carry, hi, lo}; lo starts as multiplier
   logic [CW-1:0]       cnt_q, cnt_d; // shifts performed so far
   logic [WIDTH:0]      sum;          // hi + A including carry-out

   // State and datapath registers; reset (active low) abandons any run.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         p_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update; every register holds unless its state acts.
   always_comb begin
      state_d = S_IDLE;
      a_d     = a_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      sum     = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, a_q};
      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = inA;
               p_d     = {{(WIDTH+1){1'b0}}, inB};
               cnt_d   = '0;
               state_d = S_CHECK;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            // The current multiplier bit sits in the LSB of the shift register.
            state_d = p_q[0] ? S_ADD : S_SHIFT;
         end
         S_ADD: begin
            // Carry lands in the top bit and is shifted into hi on the next step.
            p_d     = {sum, p_q[WIDTH-1:0]};
            state_d = S_SHIFT;
         end
         S_SHIFT: begin
            p_d     = {1'b0, p_q[2*WIDTH:1]};
            cnt_d   = cnt_q + 1'b1;
            state_d = (cnt_q == C_LAST) ? S_DONE : S_CHECK;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Product is visible throughout; it is only final in DONE and while idle.
   assign out_product = p_q[2*WIDTH-1:0];
   assign donee       = (state_q == S_DONE);
   assign busy        = (state_q != S_IDLE);
   assign state       = state_q;

endmodule
`default_nettype wire

// File: tb/tb_ct_mul_seq25.sv
`default_nettype none
// ============================================================================
// Module      : tb_ct_mul_seq25
// Description : Self-checking bench for ct_mul_seq25. A transaction-level model
//               predicts busy/donee/product each cycle; directed runs pin
//               literal products and latencies.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ct_mul_seq25;

   localparam int W = 25;

   logic           clk   = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [W-1:0]   inA   = '0;
   logic [W-1:0]   inB   = '0;
   logic [2*W-1:0] out_product;
   logic           donee;
   logic           busy;
   logic [2:0]     state;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ct_mul_seq25 #(.WIDTH(W), .STW(3)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .inA         (inA),
      .inB         (inB),
      .out_product (out_product),
      .donee       (donee),
      .busy        (busy),
      .state       (state)
   );

   // Transaction model: an accepted request finishes 50+popcount(B) edges
   // later with the plain arithmetic product, then returns to idle.
   bit          m_idle   = 1'b1;
   bit          m_done   = 1'b0;
   int          m_left   = 0;
   logic [49:0] m_result = '0;
   logic [49:0] m_out    = '0;

   always @(posedge clk) begin
      if (!reset) begin
         m_idle = 1'b1;
         m_done = 1'b0;
         m_left = 0;
         m_out  = '0;
      end else if (m_idle) begin
         if (start) begin
            m_idle   = 1'b0;
            m_left   = 50 + $countones(inB);
            m_result = 50'(inA) * 50'(inB);
         end
      end else if (m_done) begin
         m_done = 1'b0;
         m_idle = 1'b1;
      end else begin
         m_left = m_left - 1;
         if (m_left == 0) begin
            m_done = 1'b1;
            m_out  = m_result;
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Advance one cycle and compare the DUT against the model away from the edge.
   task automatic tick();
      @(negedge clk);
      chk("busy", busy, {63'b0, !m_idle});
      chk("donee", donee, {63'b0, m_done});
      if (m_idle)
         chk("state_idle", state, 0);
      else if (m_done)
         chk("state_done", state, 4);
      else
         chk("state_run", {63'b0, (state >= 3'd1 && state <= 3'd3)}, 1);
      if (m_idle || m_done)
         chk("product", out_product, m_out);
   endtask

   // One start pulse from idle; checks latency, result and post-done hold.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [49:0] ep, input int el);
      int n;
      inA   = a;
      inB   = b;
      start = 1'b1;
      tick();
      start = 1'b0;
      n = 0;
      while (donee !== 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("latency", n, el);
      chk("result", out_product, ep);
      tick();
      chk("idle_after", {63'b0, busy}, 0);
      chk("held", out_product, ep);
   endtask

   int          n, pulses;
   logic [W-1:0] ra, rb, rd;
   logic [63:0] dvd, q2, r2;

   initial begin
      // Reset with start held high must keep everything idle and clear.
      reset = 1'b0;
      start = 1'b1;
      inA   = 25'd2;
      inB   = 25'd3;
      repeat (3) tick();
      chk("rst_state", state, 0);
      chk("rst_prod", out_product, 0);
      chk("rst_donee", {63'b0, donee}, 0);
      chk("rst_busy", {63'b0, busy}, 0);
      reset = 1'b1;
      tick();
      chk("accept_after_rst", state, 1);
      start = 1'b0;
      n = 0;
      while (busy === 1'b1 && n < 200) begin
         tick();
         n++;
      end
      chk("first_prod", out_product, 6);

      // Directed products with hand-computed values and latencies.
      run_op(25'd3, 25'd5, 50'd15, 52);
      run_op(25'h1FFFFFF, 25'h1FFFFFF, 50'h3FFFFFC000001, 75);
      run_op(25'h1234567, 25'd0, 50'd0, 50);
      run_op(25'h0ABCDEF, 25'd1, 50'h0ABCDEF, 51);
      repeat (5) tick();
      chk("hold_idle", out_product, 50'h0ABCDEF);

      // Start while busy and operand changes mid-run must not disturb the run.
      inA   = 25'd100;
      inB   = 25'd200;
      start = 1'b1;
      tick();
      start  = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 80; k++) begin
         if (k == 10) begin
            start = 1'b1;
            inA   = 25'd5;
            inB   = 25'd7;
         end
         if (k == 11) start = 1'b0;
         if (k == 20) inA = 25'h1FFFFFF;
         tick();
         if (donee === 1'b1) begin
            pulses++;
            chk("ignored_start_result", out_product, 50'd20000);
            chk("ignored_start_latency", k, 53);
         end
      end
      chk("one_donee", pulses, 1);

      // Reset in the middle of a run abandons it without a done pulse.
      inA   = 25'd1234;
      inB   = 25'h1FFFFFF;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (19) tick();
      reset = 1'b0;
      tick();
      chk("midrst_state", state, 0);
      chk("midrst_prod", out_product, 0);
      chk("midrst_donee", {63'b0, donee}, 0);
      chk("midrst_busy", {63'b0, busy}, 0);
      reset  = 1'b1;
      pulses = 0;
      repeat (80) begin
         tick();
         if (donee === 1'b1) pulses++;
      end
      chk("midrst_no_donee", pulses, 0);
      run_op(25'd7, 25'd9, 50'd63, 52);

      // Random regression against ideal product and popcount latency.
      for (int i = 0; i < 1000; i++) begin
         ra = 25'($urandom);
         rb = 25'($urandom);
         run_op(ra, rb, 50'(ra) * 50'(rb), 50 + $countones(rb));
      end

      // Divider round trip: quotient x divisor + remainder rebuilds the dividend.
      for (int i = 0; i < 20; i++) begin
         rd  = 25'($urandom) | 25'd1;
         dvd = {32'($urandom), 32'($urandom)} % ({39'b0, rd} << 25);
         q2  = dvd / {39'b0, rd};
         r2  = dvd % {39'b0, rd};
         run_op(25'(q2), rd, 50'(dvd - r2), 50 + $countones(rd));
         chk("roundtrip", {14'b0, out_product} + r2, dvd);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
